dot_accum: RTL and testbench

DOT_ACCUM -- requirements
Module: dot_accum

---
 rtl/dot_pkg.sv | 15 +
 rtl/dot_accum_fifo.sv | 61 ++++++
 rtl/dot_accum.sv | 127 ++++++++++++
 tb/tb_dot_accum.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// Shared defaults and FSM encoding for the chunked dot-product accumulator.
package dot_pkg;
   localparam int DEF_DOT   = 128;
   localparam int DEF_SIZEA = 8;
   localparam int DEF_SIZEB = 8;
   localparam int DEF_LAT   = 10;
   localparam int DEF_DOT_W = $clog2(DEF_DOT) + DEF_SIZEA + DEF_SIZEB;
   localparam int DEF_ACC_W = 32;
   localparam int DEF_DEPTH = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } acc_state_t;
endpackage

// File: rtl/dot_accum_fifo.sv
// Show-ahead result FIFO: a push into an empty FIFO shows at head the next cycle.
// A push while full is taken only together with a pop; pop on empty is ignored.
module dot_accum_fifo
   import dot_pkg::*;
#(
   parameter int WIDTH = DEF_ACC_W + 1,
   parameter int DEPTH = DEF_DEPTH,
   localparam int CW   = $clog2(DEPTH + 1)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             not_empty,
   output logic [CW-1:0]    count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign not_empty = (count != '0);
   assign do_pop    = pop && not_empty;
   assign do_push   = push && ((count != CW'(DEPTH)) || do_pop);
   assign head      = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         if (do_push && !do_pop) begin
            count <= count + CW'(1);
         end else if (!do_push && do_pop) begin
            count <= count - CW'(1);
         end
      end
   end
endmodule

// File: rtl/dot_accum.sv
// Sums LAT-delayed dot-unit chunk results into saturating per-vector totals.
// Issue-to-out_valid is LAT+1 cycles; in_ready reserves a FIFO slot for every open last.
module dot_accum
   import dot_pkg::*;
#(
   parameter int  DOT   = DEF_DOT,
   parameter int  SIZEA = DEF_SIZEA,
   parameter int  SIZEB = DEF_SIZEB,
   parameter int  LAT   = DEF_LAT,
   parameter int  ACC_W = DEF_ACC_W,
   parameter int  DEPTH = DEF_DEPTH,
   localparam int DOT_W = $clog2(DOT) + SIZEA + SIZEB
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   input  logic [DOT_W-1:0] dot_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_sat,
   output logic             drop_err
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic [LAT-1:0]          vld_line;
   logic [LAT-1:0]          last_line;
   logic                    accept;
   logic                    arrive;
   logic                    arrive_last;
   logic                    push;
   acc_state_t              state;
   logic signed [ACC_W-1:0] acc;
   logic                    sat;
   logic signed [ACC_W-1:0] nxt_acc;
   logic                    nxt_sat;
   logic signed [ACC_W:0]   sum;
   logic signed [DOT_W-1:0] dot_s;
   logic [CW-1:0]           inflight_last;
   logic [CW-1:0]           fifo_count;
   logic [ACC_W:0]          head;
   logic                    not_empty;

   assign dot_s       = $signed(dot_in);
   assign accept      = in_valid && in_ready;
   assign arrive      = vld_line[LAT-1];
   assign arrive_last = last_line[LAT-1];
   assign push        = arrive && arrive_last;
   assign in_ready    = ({1'b0, fifo_count} + {1'b0, inflight_last}) < (CW+1)'(DEPTH);

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_line  <= '0;
         last_line <= '0;
      end else begin
         vld_line[0]  <= accept;
         last_line[0] <= accept && in_last;
         for (int i = 1; i < LAT; i++) begin
            vld_line[i]  <= vld_line[i-1];
            last_line[i] <= last_line[i-1];
         end
      end
   end

   // One guard bit is enough: its disagreement with the MSB marks an overflow.
   always_comb begin
      sum     = (ACC_W+1)'(acc) + (ACC_W+1)'(dot_s);
      nxt_acc = sum[ACC_W-1:0];
      nxt_sat = sat;
      if (state == ST_IDLE) begin
         nxt_acc = ACC_W'(dot_s);
         nxt_sat = 1'b0;
      end else if (!sum[ACC_W] && sum[ACC_W-1]) begin
         nxt_acc = ACC_MAX;
         nxt_sat = 1'b1;
      end else if (sum[ACC_W] && !sum[ACC_W-1]) begin
         nxt_acc = ACC_MIN;
         nxt_sat = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         acc           <= '0;
         sat           <= 1'b0;
         inflight_last <= '0;
         drop_err      <= 1'b0;
      end else begin
         if (in_valid && !in_ready) begin
            drop_err <= 1'b1;
         end
         case ({accept && in_last, push})
            2'b10:   inflight_last <= inflight_last + CW'(1);
            2'b01:   inflight_last <= inflight_last - CW'(1);
            default: inflight_last <= inflight_last;
         endcase
         if (arrive) begin
            acc   <= nxt_acc;
            sat   <= nxt_sat;
            state <= arrive_last ? ST_IDLE : ST_ACCUM;
         end
      end
   end

   dot_accum_fifo #(
      .WIDTH (ACC_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({nxt_acc, nxt_sat}),
      .pop       (out_valid && out_ready),
      .head      (head),
      .not_empty (not_empty),
      .count     (fifo_count)
   );

   assign out_valid = not_empty;
   assign out_data  = not_empty ? head[ACC_W:1] : '0;
   assign out_sat   = not_empty && head[0];
endmodule

// File: tb/tb_dot_accum.sv
// Randomized and directed bench for dot_accum, scored against a per-vector arithmetic model.
module tb_dot_accum;
   localparam int LAT   = 10;
   localparam int ACC_W = 24;
   localparam int DEPTH = 4;
   localparam int DOT_W = 23;
   localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_last = 1'b0;
   logic             in_ready;
   logic [DOT_W-1:0] dot_in = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] out_data;
   logic             out_sat;
   logic             drop_err;

   dot_accum #(
      .LAT   (LAT),
      .ACC_W (ACC_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .dot_in    (dot_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .drop_err  (drop_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint val;
      bit     sat;
      longint arr;
   } exp_t;

   exp_t   exp_q[$];
   int     n_cmp = 0;
   int     n_err = 0;
   bit     open_m = 0;
   longint psum = 0;
   bit     psat = 0;
   bit     drop_m = 0;
   longint edge_n = 0;
   bit     ring_v[16];
   longint ring_d[16];

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint rnd_val();
      if ($urandom_range(0, 3) == 0)
         return longint'($urandom_range(0, 2000)) - 1000;
      return longint'($urandom_range(0, 8388607)) - 4194304;
   endfunction

   // Vector result per the arithmetic rules: first chunk loads, later chunks add with clamp.
   task automatic model_chunk(input longint v, input bit last);
      longint s;
      if (!open_m) begin
         psum = v;
         psat = 0;
      end else begin
         s = psum + v;
         if (s > MAXV) begin
            s = MAXV;
            psat = 1;
         end else if (s < MINV) begin
            s = MINV;
            psat = 1;
         end
         psum = s;
      end
      if (last) begin
         exp_q.push_back('{psum, psat, edge_n + LAT});
         open_m = 0;
      end else begin
         open_m = 1;
      end
   endtask

   task automatic step(input bit iv, input bit il, input longint v, input bit ordy, output bit took);
      int   aslot;
      int   slot;
      bit   exp_ov;
      exp_t f;
      took = 0;
      @(negedge clk);
      chk("in_ready", in_ready, (exp_q.size() < DEPTH));
      chk("drop_err", drop_err, drop_m);
      out_ready = ordy;
      exp_ov = (exp_q.size() > 0) && (exp_q[0].arr < edge_n);
      chk("out_valid", out_valid, exp_ov);
      if (out_valid && ordy && exp_q.size() > 0) begin
         f = exp_q.pop_front();
         chk("out_data", $signed(out_data), f.val);
         chk("out_sat", out_sat, f.sat);
      end
      aslot = int'((edge_n + 16 - LAT) % 16);
      if (edge_n >= LAT && ring_v[aslot]) begin
         dot_in = DOT_W'(ring_d[aslot]);
      end else begin
         dot_in = DOT_W'($urandom);
      end
      slot = int'(edge_n % 16);
      ring_v[slot] = 0;
      if (iv) begin
         if (in_ready) begin
            ring_v[slot] = 1;
            ring_d[slot] = v;
            model_chunk(v, il);
            took = 1;
         end else begin
            drop_m = 1;
         end
      end
      in_valid = iv;
      in_last  = il;
      edge_n++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      in_valid = 0;
      in_last = 0;
      dot_in = DOT_W'($urandom);
      edge_n++;
      repeat (3) begin
         @(negedge clk);
         dot_in = DOT_W'($urandom);
         edge_n++;
      end
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_drop_err", drop_err, 0);
      chk("rst_in_ready", in_ready, 1);
      rst = 0;
      exp_q.delete();
      open_m = 0;
      drop_m = 0;
      for (int i = 0; i < 16; i++) ring_v[i] = 0;
   endtask

   task automatic idle(input int n, input bit ordy);
      bit t;
      repeat (n) step(0, 0, 0, ordy, t);
   endtask

   task automatic drain();
      int budget;
      budget = 200;
      while (exp_q.size() > 0 && budget > 0) begin
         idle(1, 1);
         budget--;
      end
      chk("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      bit  t;
      bit  iv;
      bit  ordy;
      int  rem;
      do_reset();

      // single chunk
      step(1, 1, 1000, 1, t);
      idle(LAT + 3, 1);
      // three chunks to one result
      step(1, 0, 100, 1, t);
      step(1, 0, -50, 1, t);
      step(1, 1, 7, 1, t);
      idle(LAT + 3, 1);
      // saturation then clean vector
      for (int i = 0; i < 5; i++) step(1, (i == 4), 2097152, 1, t);
      step(1, 1, 5, 1, t);
      idle(LAT + 3, 1);
      // fill with consumer stalled, then overflow attempt
      for (int i = 0; i < 4; i++) step(1, 1, 11 * (i + 1), 0, t);
      step(1, 1, 999, 0, t);
      idle(LAT + 4, 0);
      drain();

      // reset mid-vector with chunks in flight
      step(1, 0, 123, 1, t);
      idle(LAT, 1);
      for (int i = 0; i < 3; i++) step(1, 0, 77, 1, t);
      do_reset();
      idle(LAT + 4, 1);
      step(1, 1, 42, 1, t);
      idle(LAT + 3, 1);

      rem = $urandom_range(1, 6);
      for (int c = 0; c < 2500; c++) begin
         iv   = ($urandom_range(0, 99) < 65);
         ordy = ((c % 300) < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
         step(iv, (rem == 1), rnd_val(), ordy, t);
         if (t) begin
            rem--;
            if (rem == 0) rem = $urandom_range(1, 6);
         end
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
